servant_spi_ram_ctrl: RTL and testbench
=======================================

# servant_spi_ram_ctrl

SPI-slave command sequencer that owns the byte-wide servant SPI RAM array. It oversamples an external mode-0 SPI bus on the system clock and decodes READ/WRITE commands with a 24-bit address. It drives the RAM port with one-cycle write strobes and read requests, auto-incrementing the address. It sits between the SPI pads and the RAM array, so a SERV core or testbench master sees a standard serial SRAM.

## Interface
- `depth`, 65536: RAM size in bytes; must match the attached array.
- `aw`, `$clog2(depth)`: RAM address width; the low `aw` bits of the 24-bit SPI address are used and the upper bits are ignored.
- `i_clk`, in, 1: system clock; all logic on rising edge.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_sck`, in, 1: SPI clock, asynchronous to `i_clk`, mode 0.
- `i_cs_n`, in, 1: SPI chip select, active low, asynchronous.
- `i_mosi`, in, 1: SPI data in, asynchronous.
- `o_miso`, out, 1: SPI data out, MSB first.
- `o_ram_addr`, out, aw: RAM byte address.
- `o_ram_wdata`, out, 8: RAM write byte.
- `o_ram_we_n`, out, 1: RAM write strobe, active low, one `i_clk` wide.
- `o_ram_re`, out, 1: RAM read request, one `i_clk` wide.
- `i_ram_rdata`, in, 8: RAM read byte, valid on the 1st `i_clk` rising edge after `o_ram_re`.
- `o_busy`, out, 1: high from the detected CS fall to the detected CS rise.

## Operation
- Reset values:
  - `o_miso`=0, `o_ram_addr`=0, `o_ram_wdata`=0.
  - `o_ram_we_n`=1, `o_ram_re`=0, `o_busy`=0.
  - State=IDLE.
- Synchronization: `i_sck`, `i_cs_n` and `i_mosi` each pass through a 2-flop synchronizer. Edge detection compares against a 3rd flop.
- Shift behaviour: MOSI is sampled at the detected SCK rise. MISO is updated at the detected SCK fall. Bit order is MSB first.
- States:
  - IDLE → CMD on a CS fall.
  - CMD (8 bits) → ADDR if opcode is 0x03 or 0x02, else IGNORE.
  - ADDR (24 bits) → RD or WR.
  - IGNORE: holds until CS rises; no RAM access; MISO=0.
- Any state returns to IDLE on a detected CS rise. That transition has priority over a same-cycle SCK edge.
- RD:
  - On the cycle after the 24th address bit, pulse `o_ram_re` with the address.
  - Capture `i_ram_rdata` into the MISO shift register. The 1st SCK fall after that presents the data MSB.
  - At the SCK rise of bit 0 of each byte, increment the address and pulse `o_ram_re` for the prefetch.
  - Load the prefetched byte at the next SCK fall.
- WR:
  - After each 8th data bit, pulse `o_ram_we_n` low for 1 cycle with address and byte stable.
  - Increment the address on the following cycle.
- Address arithmetic: the address wraps modulo `depth`, so depth−1 is followed by 0.
- Aborts:
  - A CS rise mid-byte in WR discards the partial byte; no strobe is issued.
  - A CS rise in RD drops any pending prefetch with no side effect.
- Reset mid-transaction returns to IDLE immediately. The next transaction starts only on a fresh detected CS fall.

## Timing
- Input-to-detect latency: 3 `i_clk` cycles from a pin edge to the internal edge pulse.
- Required f_clk ≥ 8 × f_sck. The SCK high and low phases must each be at least 4 `i_clk` cycles.
- Write strobe: issued 1 cycle after the detected rise of the 8th bit.
- Read data: on MISO at most 2 cycles after the detected SCK fall. This holds only if the prefetch completed, which the clock ratio guarantees.
- Minimum CS-high time between transactions: 4 `i_clk` cycles.

## Configuration
- `SERVANT_SPI_RAM_FAST_READ_EN` defined: opcode 0x0B (FAST READ) is accepted. It behaves like READ, but 8 dummy SCK cycles (state DUMMY, MISO=0) follow the address. The first RAM read is issued after the last dummy bit.
- Undefined: 0x0B goes to IGNORE.

## Structure
- Package `servant_spi_ram_pkg`:
  - opcode constants OP_READ=8'h03, OP_WRITE=8'h02, OP_FAST_READ=8'h0B;
  - state enum IDLE/CMD/ADDR/DUMMY/RD/WR/IGNORE.
- Sub-module `servant_spi_sync` is used three times. It is a 2-flop synchronizer plus edge-detect flop, with outputs level, rise and fall; it resets to sync value 1 for `i_cs_n` and 0 otherwise.
- The bit counter (5 bits) and shift registers stay in the top level.

## Test plan
- Send CS low, 0x02, addr 0x000010, data 0xA5 then 0x5A, CS high → strobes write 0xA5@0x10 and 0x5A@0x11, exactly two `o_ram_we_n` pulses.
- Send 0x03, addr 0x000010, clock 16 bits → MISO returns 0xA5 then 0x5A.
- With `depth`=65536, write 0x11 and 0x22 starting at 0x00FFFF → RAM bytes 0xFFFF=0x11 and 0x0000=0x22.
- Send 0x02, addr 0x000020, 4 data bits, CS high → no write strobe; a later read of 0x20 returns the prior value.
- Send opcode 0x9F plus 32 clocks → no `o_ram_re`/`o_ram_we_n` activity, MISO stays 0, `o_busy` falls after CS rises.
- With the macro defined, send 0x0B, addr 0x10, 8 dummy clocks, then 8 clocks → MISO 0xA5. Without the macro → MISO 0 and no RAM access.

Source files
------------

// File: rtl/servant_spi_ram_pkg.sv
// Shared opcodes and sequencer states for the servant SPI RAM controller.
package servant_spi_ram_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD,
    WR,
    IGNORE
  } state_t;

endpackage

// File: rtl/servant_spi_sync.sv
// Two-flop synchronizer with a third flop for rise/fall detection.
module servant_spi_sync #(
  parameter logic rst_val = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= rst_val;
      sync_p1 <= rst_val;
      sync_p2 <= rst_val;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~sync_p2;
  assign fall  = ~sync_p1 & sync_p2;

endmodule

// File: rtl/servant_spi_ram_ctrl.sv
// SPI-slave READ/WRITE sequencer for the byte-wide servant RAM (mode 0, oversampled).
// Define SERVANT_SPI_RAM_FAST_READ_EN to accept opcode 0x0B with 8 dummy clocks.
module servant_spi_ram_ctrl
  import servant_spi_ram_pkg::*;
#(
  parameter int depth = 65536,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_sck,
  input  logic          i_cs_n,
  input  logic          i_mosi,
  output logic          o_miso,
  output logic [aw-1:0] o_ram_addr,
  output logic [7:0]    o_ram_wdata,
  output logic          o_ram_we_n,
  output logic          o_ram_re,
  input  logic [7:0]    i_ram_rdata,
  output logic          o_busy
);

  localparam logic [aw-1:0] addr_one = 1;

  logic       sck_lvl, sck_rise, sck_fall;
  logic       cs_lvl, cs_rise, cs_fall;
  logic       mosi_lvl, mosi_rise, mosi_fall;
  logic       unused_sync;
  state_t     state, next_state;
  logic [4:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] opcode;
  logic       fast_cmd, rd_op, fast_op;
  logic [7:0] rd_buf, miso_sr;
  logic       re_d, load_pend;

  servant_spi_sync #(.rst_val(1'b0)) u_sync_sck (
    .clk(i_clk), .rst_n(i_rst_n), .d(i_sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  servant_spi_sync #(.rst_val(1'b1)) u_sync_cs (
    .clk(i_clk), .rst_n(i_rst_n), .d(i_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  servant_spi_sync #(.rst_val(1'b0)) u_sync_mosi (
    .clk(i_clk), .rst_n(i_rst_n), .d(i_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall};
  assign opcode      = {shift_in, mosi_lvl};
  assign o_busy      = (state != IDLE);

`ifdef SERVANT_SPI_RAM_FAST_READ_EN
  assign fast_cmd = (opcode == OP_FAST_READ);
`else
  assign fast_cmd = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // CS rise outranks any same-cycle SCK edge.
  always_comb begin
    next_state = state;
    if (cs_rise) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:  if (cs_fall) next_state = CMD;
        CMD:   if (sck_rise && bit_cnt == 5'd7) begin
                 if (opcode == OP_READ || opcode == OP_WRITE || fast_cmd) next_state = ADDR;
                 else                                                    next_state = IGNORE;
               end
        ADDR:  if (sck_rise && bit_cnt == 5'd23) next_state = fast_op ? DUMMY : (rd_op ? RD : WR);
        DUMMY: if (sck_rise && bit_cnt == 5'd7) next_state = RD;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt     <= '0;
      shift_in    <= '0;
      rd_op       <= 1'b0;
      fast_op     <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
      o_ram_we_n  <= 1'b1;
      o_ram_re    <= 1'b0;
      o_miso      <= 1'b0;
      rd_buf      <= '0;
      miso_sr     <= '0;
      re_d        <= 1'b0;
      load_pend   <= 1'b0;
    end else begin
      o_ram_re   <= 1'b0;
      o_ram_we_n <= 1'b1;
      re_d       <= o_ram_re;
      if (state != next_state) bit_cnt <= '0;
      else if (sck_rise)       bit_cnt <= bit_cnt + 5'd1;

      if (cs_rise) begin
        re_d      <= 1'b0;
        load_pend <= 1'b0;
        o_miso    <= 1'b0;
      end else begin
        // Read data arrives one cycle after the RAM registers the request.
        if (re_d && state == RD) begin
          rd_buf    <= i_ram_rdata;
          load_pend <= 1'b1;
        end
        if (!o_ram_we_n) o_ram_addr <= o_ram_addr + addr_one;

        if (sck_rise) begin
          case (state)
            CMD: begin
              shift_in <= {shift_in[5:0], mosi_lvl};
              if (bit_cnt == 5'd7) begin
                rd_op   <= (opcode != OP_WRITE);
                fast_op <= fast_cmd;
              end
            end
            ADDR: begin
              o_ram_addr <= {o_ram_addr[aw-2:0], mosi_lvl};
              if (next_state == RD) o_ram_re <= 1'b1;
            end
            DUMMY: if (next_state == RD) o_ram_re <= 1'b1;
            RD: if (bit_cnt[2:0] == 3'd7) begin
              o_ram_addr <= o_ram_addr + addr_one;
              o_ram_re   <= 1'b1;
            end
            WR: begin
              shift_in <= {shift_in[5:0], mosi_lvl};
              if (bit_cnt[2:0] == 3'd7) begin
                o_ram_wdata <= {shift_in, mosi_lvl};
                o_ram_we_n  <= 1'b0;
              end
            end
            default: ;
          endcase
        end

        if (sck_fall && state == RD) begin
          if (load_pend) begin
            o_miso    <= rd_buf[7];
            miso_sr   <= {rd_buf[6:0], 1'b0};
            load_pend <= 1'b0;
          end else begin
            o_miso  <= miso_sr[7];
            miso_sr <= {miso_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_servant_spi_ram_ctrl.sv
// Directed bench: SPI master driving servant_spi_ram_ctrl with a behavioural byte RAM.
module tb_servant_spi_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we_n;
  logic        ram_re;
  logic [7:0]  ram_rdata = 8'h00;
  logic        busy;

  logic [7:0]  mem [0:65535];
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  servant_spi_ram_ctrl #(.depth(65536)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(miso), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .o_ram_we_n(ram_we_n), .o_ram_re(ram_re), .i_ram_rdata(ram_rdata), .o_busy(busy)
  );

  // Registered-read RAM plus strobe counters.
  always @(posedge clk) begin
    if (!ram_we_n) begin
      mem[ram_addr] <= ram_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (ram_re) begin
      ram_rdata <= mem[ram_addr];
      re_cnt <= re_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: MOSI set while SCK low, MISO sampled just before the rising edge.
  task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = tx[i];
      wait_clk(8);
      rx[i] = miso;
      sck = 1'b1;
      wait_clk(8);
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(10);
  endtask

  logic [31:0] rx;
  logic [31:0] rx_d;
  int          we0, re0;

  initial begin
    wait_clk(3);
    check("rst_miso",  {31'b0, miso},     32'h0);
    check("rst_addr",  {16'b0, ram_addr}, 32'h0);
    check("rst_wdata", {24'b0, ram_wdata}, 32'h0);
    check("rst_we_n",  {31'b0, ram_we_n}, 32'h1);
    check("rst_re",    {31'b0, ram_re},   32'h0);
    check("rst_busy",  {31'b0, busy},     32'h0);
    rst_n = 1'b1;
    wait_clk(5);

    // Write 0xA5, 0x5A at 0x10
    we0 = we_cnt;
    cs_low();
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h000010, 24, rx);
    spi_bits(32'hA5, 8, rx);
    spi_bits(32'h5A, 8, rx);
    check("wr_busy_hi", {31'b0, busy}, 32'h1);
    cs_high();
    check("wr_busy_lo", {31'b0, busy}, 32'h0);
    check("wr_strobes", we_cnt - we0, 32'd2);
    check("wr_mem10", {24'b0, mem[16'h0010]}, 32'hA5);
    check("wr_mem11", {24'b0, mem[16'h0011]}, 32'h5A);

    // Read back two bytes from 0x10
    re0 = re_cnt;
    cs_low();
    spi_bits(32'h03, 8, rx);
    spi_bits(32'h000010, 24, rx);
    spi_bits(32'h0, 16, rx);
    cs_high();
    check("rd_data", rx, 32'h0000A55A);
    check("rd_reqs", re_cnt - re0, 32'd3);

    // Address wrap at depth-1
    cs_low();
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h00FFFF, 24, rx);
    spi_bits(32'h11, 8, rx);
    spi_bits(32'h22, 8, rx);
    cs_high();
    check("wrap_memFFFF", {24'b0, mem[16'hFFFF]}, 32'h11);
    check("wrap_mem0000", {24'b0, mem[16'h0000]}, 32'h22);
    check("wrap_addr", {16'b0, ram_addr}, 32'h0001);

    // Seed 0x20, then abort a write after 4 data bits
    cs_low();
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h000020, 24, rx);
    spi_bits(32'h3C, 8, rx);
    cs_high();
    we0 = we_cnt;
    cs_low();
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h000020, 24, rx);
    spi_bits(32'hF, 4, rx);
    cs_high();
    check("abort_strobes", we_cnt - we0, 32'd0);
    cs_low();
    spi_bits(32'h03, 8, rx);
    spi_bits(32'h000020, 24, rx);
    spi_bits(32'h0, 8, rx);
    cs_high();
    check("abort_readback", rx, 32'h3C);

    // Unknown opcode is ignored
    we0 = we_cnt;
    re0 = re_cnt;
    cs_low();
    spi_bits(32'h9F, 8, rx);
    spi_bits(32'hFFFFFFFF, 32, rx);
    check("ign_miso", rx, 32'h0);
    check("ign_busy_hi", {31'b0, busy}, 32'h1);
    cs_high();
    check("ign_busy_lo", {31'b0, busy}, 32'h0);
    check("ign_we", we_cnt - we0, 32'd0);
    check("ign_re", re_cnt - re0, 32'd0);

    // Fast read at 0x10
    re0 = re_cnt;
    cs_low();
    spi_bits(32'h0B, 8, rx);
    spi_bits(32'h000010, 24, rx);
    spi_bits(32'h0, 8, rx_d);
    spi_bits(32'h0, 8, rx);
    cs_high();
    check("fast_dummy_miso", rx_d, 32'h0);
`ifdef SERVANT_SPI_RAM_FAST_READ_EN
    check("fast_data", rx, 32'hA5);
    check("fast_reqs", re_cnt - re0, 32'd2);
`else
    check("fast_off_miso", rx, 32'h0);
    check("fast_off_reqs", re_cnt - re0, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
